// File: rtl/oled_spi_receiver_if.sv
// Display SPI link lines plus the consumer-side FIFO handshake and flags.
// The master drives the link and pops; the slave is the receiver.
interface oled_spi_receiver_if;
    logic       SCLK;
    logic       nCS;
    logic       DnC;
    logic       SDIN;
    logic       RdEn;
    logic       ClearFlags;
    logic       RxValid;
    logic [7:0] RxData;
    logic       RxIsData;
    logic       Overflow;
    logic       FrameErr;

    modport master (
        output SCLK, nCS, DnC, SDIN, RdEn, ClearFlags,
        input  RxValid, RxData, RxIsData, Overflow, FrameErr
    );

    modport slave (
        input  SCLK, nCS, DnC, SDIN, RdEn, ClearFlags,
        output RxValid, RxData, RxIsData, Overflow, FrameErr
    );
endinterface

// File: rtl/oled_spi_receiver.sv
// Oversampling receiver for the OLED write-only SPI link (mode 0, MSB first)
// with a show-ahead byte FIFO and sticky overflow / framing-error flags.
module oled_spi_receiver #(
    parameter int DEPTH = 4
) (
    input logic Clock,
    input logic nReset,
    oled_spi_receiver_if.slave link
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FullCnt = (AW+1)'(DEPTH);

    // bit [1] of each pipe is the synchronized value
    logic [1:0]    sclkPipe, ncsPipe, dncPipe, sdinPipe;
    logic          sclkPrev, ncsPrev;
    logic [2:0]    bitCnt;
    logic [7:0]    shiftReg;
    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wrPtr, rdPtr;
    logic [AW:0]   count;
    logic          overflow, frameErr;

    logic sclkRise, ncsRise, ncsFall, capture;
    logic push, pop, full, doPush, ovfSet, ferrSet;

    assign sclkRise = sclkPipe[1] & ~sclkPrev;
    assign ncsRise  = ncsPipe[1] & ~ncsPrev;
    assign ncsFall  = ~ncsPipe[1] & ncsPrev;
    assign capture  = sclkRise & ~ncsPipe[1] & ~ncsFall;

    assign push    = capture & (bitCnt == 3'd7);
    assign pop     = link.RdEn & (count != '0);
    assign full    = (count == FullCnt);
    assign doPush  = push & (~full | pop);
    assign ovfSet  = push & full & ~pop;
    assign ferrSet = ncsRise & (bitCnt != 3'd0);

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            sclkPipe <= 2'b00;
            ncsPipe  <= 2'b11;
            dncPipe  <= 2'b00;
            sdinPipe <= 2'b00;
            sclkPrev <= 1'b0;
            ncsPrev  <= 1'b1;
        end else begin
            sclkPipe <= {sclkPipe[0], link.SCLK};
            ncsPipe  <= {ncsPipe[0], link.nCS};
            dncPipe  <= {dncPipe[0], link.DnC};
            sdinPipe <= {sdinPipe[0], link.SDIN};
            sclkPrev <= sclkPipe[1];
            ncsPrev  <= ncsPipe[1];
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            bitCnt   <= 3'd0;
            shiftReg <= 8'h00;
        end else if (ncsRise | ncsFall) begin
            bitCnt <= 3'd0;
        end else if (capture) begin
            bitCnt   <= bitCnt + 3'd1;
            shiftReg <= {shiftReg[6:0], sdinPipe[1]};
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                mem[wrPtr] <= {dncPipe[1], shiftReg[6:0], sdinPipe[1]};
                wrPtr      <= wrPtr + AW'(1);
            end
            if (pop) rdPtr <= rdPtr + AW'(1);
            unique case ({doPush, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // a set in the same cycle as a clear wins
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            overflow <= 1'b0;
            frameErr <= 1'b0;
        end else begin
            overflow <= (overflow & ~link.ClearFlags) | ovfSet;
            frameErr <= (frameErr & ~link.ClearFlags) | ferrSet;
        end
    end

    assign link.RxValid  = (count != '0);
    assign link.RxData   = link.RxValid ? mem[rdPtr][7:0] : 8'h00;
    assign link.RxIsData = link.RxValid & mem[rdPtr][8];
    assign link.Overflow = overflow;
    assign link.FrameErr = frameErr;
endmodule

// File: tb/tb_oled_spi_receiver.sv
// Scoreboard bench for oled_spi_receiver: drives SPI frames, models the FIFO
// occupancy and overflow, and checks popped bytes, latency and flags.
module tb_oled_spi_receiver;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic nReset = 1'b0;
    oled_spi_receiver_if bus();

    oled_spi_receiver #(.DEPTH(DEPTH)) dut (
        .Clock  (clk),
        .nReset (nReset),
        .link   (bus.slave)
    );

    always #5 clk = ~clk;

    int nVec = 0;
    int nErr = 0;
    logic [8:0] expQ[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // mode 0: plain bit, 1: check push latency, 2: pop on the push cycle
    task automatic sendBit(input logic b, input logic dc, input int mode);
        logic [8:0] e;
        bus.SDIN = b;
        bus.DnC  = dc;
        repeat (4) @(negedge clk);
        bus.SCLK = 1'b1;
        if (mode == 1) begin
            repeat (2) @(negedge clk);
            chk("latPre", bus.RxValid, 0);
            @(negedge clk);
            chk("latPost", bus.RxValid, 1);
            @(negedge clk);
        end else if (mode == 2) begin
            repeat (2) @(negedge clk);
            e = expQ.pop_front();
            chk("popPushData", bus.RxData, e[7:0]);
            bus.RdEn = 1'b1;
            @(negedge clk);
            bus.RdEn = 1'b0;
            @(negedge clk);
        end else begin
            repeat (4) @(negedge clk);
        end
        bus.SCLK = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] v, input logic dc,
                            input int mode);
        for (int i = 7; i >= 0; i--)
            sendBit(v[i], dc, (i == 0) ? mode : 0);
        if (expQ.size() < DEPTH) expQ.push_back({dc, v});
    endtask

    task automatic csLow();
        bus.nCS = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic csHigh();
        repeat (4) @(negedge clk);
        bus.nCS = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic popOne();
        logic [8:0] e;
        int n;
        n = 0;
        while (!bus.RxValid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("popValid", bus.RxValid, 1);
        if (expQ.size() == 0) begin
            chk("scoreboardEmpty", 0, 1);
        end else begin
            e = expQ.pop_front();
            chk("popData", bus.RxData, e[7:0]);
            chk("popTag", bus.RxIsData, e[8]);
        end
        bus.RdEn = 1'b1;
        @(negedge clk);
        bus.RdEn = 1'b0;
    endtask

    task automatic pulseClear();
        bus.ClearFlags = 1'b1;
        @(negedge clk);
        bus.ClearFlags = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        bus.SCLK = 1'b0;
        bus.nCS = 1'b1;
        bus.DnC = 1'b0;
        bus.SDIN = 1'b0;
        bus.RdEn = 1'b0;
        bus.ClearFlags = 1'b0;
        repeat (3) @(negedge clk);
        chk("rstValid", bus.RxValid, 0);
        chk("rstData", bus.RxData, 8'h00);
        chk("rstTag", bus.RxIsData, 0);
        chk("rstOvf", bus.Overflow, 0);
        chk("rstFerr", bus.FrameErr, 0);
        nReset = 1'b1;
        repeat (3) @(negedge clk);

        // single command byte with latency check
        csLow();
        sendByte(8'hAE, 1'b0, 1);
        csHigh();
        chk("t1Ferr", bus.FrameErr, 0);
        popOne();

        // two data bytes in one frame
        csLow();
        sendByte(8'h55, 1'b1, 0);
        sendByte(8'hAA, 1'b1, 0);
        csHigh();
        popOne();
        popOne();
        chk("t2Empty", bus.RxValid, 0);

        // truncated byte then a clean one
        csLow();
        for (int i = 0; i < 5; i++) sendBit(1'b1, 1'b0, 0);
        csHigh();
        chk("t3Ferr", bus.FrameErr, 1);
        chk("t3NoByte", bus.RxValid, 0);
        csLow();
        sendByte(8'h3C, 1'b0, 0);
        csHigh();
        popOne();
        pulseClear();
        chk("t3FerrClr", bus.FrameErr, 0);

        // overflow, then push+pop while full
        csLow();
        for (int v = 1; v <= 5; v++) sendByte(8'(v), 1'b1, 0);
        chk("t4Ovf", bus.Overflow, 1);
        sendByte(8'h06, 1'b1, 2);
        csHigh();
        chk("t4OvfHeld", bus.Overflow, 1);
        for (int i = 0; i < DEPTH; i++) popOne();
        chk("t4Empty", bus.RxValid, 0);
        pulseClear();
        chk("t4OvfClr", bus.Overflow, 0);

        // SCLK activity with nCS high is ignored
        bus.nCS = 1'b1;
        for (int i = 0; i < 8; i++) sendBit(1'b1, 1'b1, 0);
        repeat (4) @(negedge clk);
        chk("t5NoByte", bus.RxValid, 0);
        chk("t5Ovf", bus.Overflow, 0);
        chk("t5Ferr", bus.FrameErr, 0);
        csLow();
        sendByte(8'h81, 1'b0, 0);
        csHigh();
        popOne();

        // reset with two bytes buffered and a partial byte in flight
        csLow();
        sendByte(8'h11, 1'b1, 0);
        sendByte(8'h22, 1'b0, 0);
        for (int i = 0; i < 4; i++) sendBit(1'b1, 1'b1, 0);
        chk("t6Buffered", bus.RxValid, 1);
        nReset = 1'b0;
        #1;
        chk("t6RstValid", bus.RxValid, 0);
        chk("t6RstData", bus.RxData, 8'h00);
        chk("t6RstTag", bus.RxIsData, 0);
        chk("t6RstOvf", bus.Overflow, 0);
        chk("t6RstFerr", bus.FrameErr, 0);
        expQ.delete();
        bus.nCS = 1'b1;
        repeat (3) @(negedge clk);
        nReset = 1'b1;
        repeat (4) @(negedge clk);
        chk("t6NoFerr", bus.FrameErr, 0);
        csLow();
        sendByte(8'h9C, 1'b1, 0);
        csHigh();
        popOne();
        chk("t6Empty", bus.RxValid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule
